ball_handoff_sequencer: RTL and testbench

BALL_HANDOFF_SEQUENCER -- requirements
Module: ball_handoff_sequencer

---
 rtl/handoff_pkg.sv | 34 +++
 rtl/ball_handoff_sequencer_if.sv | 21 ++
 rtl/handoff_frame_packer.sv | 25 ++
 rtl/ball_handoff_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ball_handoff_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/handoff_pkg.sv
// Shared types and constants for the ball handoff sequencer: FSM states,
// frame layout and parameter defaults.
package handoff_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_WAIT_DONE,
    S_BACKOFF,
    S_REPORT
  } state_t;

  localparam int FRAME_LEN = 5;

  // B0 carries the two high Y bits at the top and the lose flag at bit 0.
  localparam int   B0_Y_HI_MSB = 7;
  localparam int   B0_Y_HI_LSB = 6;
  localparam int   B0_LOSE_BIT = 0;
  localparam logic LOSE_FLAG   = 1'b1;

  localparam int DEF_MAX_RETRY   = 3;
  localparam int DEF_TIMEOUT_CYC = 25000;
  localparam int DEF_BACKOFF_CYC = 2500;

  typedef struct packed {
    logic       is_lose;
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] gravity;
    logic       fast;
  } frame_fields_t;

endpackage

// File: rtl/ball_handoff_sequencer_if.sv
// Byte-stream link between the handoff sequencer and the I2C master engine.
interface ball_handoff_sequencer_if;
  // A byte moves on a rising clk edge where i2c_tx_valid && i2c_tx_ready; while
  // valid is high, data is held stable and valid is not withdrawn until accepted.
  logic       i2c_start;
  logic [7:0] i2c_tx_data;
  logic       i2c_tx_valid;
  logic       i2c_tx_ready;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_start, i2c_tx_data, i2c_tx_valid,
    input  i2c_tx_ready, i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_start, i2c_tx_data, i2c_tx_valid,
    output i2c_tx_ready, i2c_done, i2c_nack
  );
endinterface

// File: rtl/handoff_frame_packer.sv
// Maps the latched frame fields and the current byte index to the outgoing byte.
module handoff_frame_packer
  import handoff_pkg::*;
(
  input  frame_fields_t fields,
  input  logic [2:0]    byte_idx,
  output logic [7:0]    tx_byte
);

  always_comb begin
    tx_byte = '0;
    case (byte_idx)
      3'd0: begin
        tx_byte[B0_Y_HI_MSB:B0_Y_HI_LSB] = fields.y[9:8];
        tx_byte[B0_LOSE_BIT]             = fields.is_lose;
      end
      3'd1:    tx_byte = fields.y[7:0];
      3'd2:    tx_byte = fields.vy;
      3'd3:    tx_byte = {6'b0, fields.gravity};
      3'd4:    tx_byte = {7'b0, fields.fast};
      default: tx_byte = '0;
    endcase
  end

endmodule

// File: rtl/ball_handoff_sequencer.sv
// Sends a 5-byte ball or lose frame over I2C on a trigger edge, with timeout,
// bounded retries separated by a backoff wait, and completion/overrun reporting.
module ball_handoff_sequencer
  import handoff_pkg::*;
#(
  parameter int MAX_RETRY   = DEF_MAX_RETRY,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int BACKOFF_CYC = DEF_BACKOFF_CYC
) (
  input  logic                            clk_25MHZ,
  input  logic                            reset_n,
  input  logic                            ball_send_trigger,
  input  logic                            send_lose_information,
  input  logic [9:0]                      ball_y_in,
  input  logic [7:0]                      ball_vy_in,
  input  logic [1:0]                      gravity_in,
  input  logic                            fast_speed_in,
  ball_handoff_sequencer_if.master        i2c,
  output logic                            busy,
  output logic                            frame_ok,
  output logic                            frame_fail,
  output logic                            overrun,
  output state_t                          dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BO_W  = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t            state_q, state_d;
  frame_fields_t     fields_q, fields_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [BO_W-1:0]   bo_cnt_q, bo_cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic              ball_prev_q, ball_prev_d;
  logic              lose_prev_q, lose_prev_d;
  logic              armed_q, armed_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;
  logic              overrun_q, overrun_d;

  logic              ball_edge, lose_edge, any_edge;
  logic              accepted, timed_out, attempt_fail;
  logic [7:0]        packed_byte;

  handoff_frame_packer u_packer (
    .fields   (fields_q),
    .byte_idx (byte_idx_q),
    .tx_byte  (packed_byte)
  );

  always_comb begin
    // armed_q keeps a level already high at reset release from looking like an edge
    ball_edge    = armed_q & ball_send_trigger & ~ball_prev_q;
    lose_edge    = armed_q & send_lose_information & ~lose_prev_q;
    any_edge     = ball_edge | lose_edge;
    accepted     = valid_q & i2c.i2c_tx_ready;
    timed_out    = (tmo_cnt_q >= TMO_W'(TIMEOUT_CYC));
    attempt_fail = 1'b0;

    ball_prev_d  = ball_send_trigger;
    lose_prev_d  = send_lose_information;
    armed_d      = 1'b1;
    state_d      = state_q;
    fields_d     = fields_q;
    byte_idx_d   = byte_idx_q;
    tmo_cnt_d    = '0;
    bo_cnt_d     = '0;
    retry_d      = retry_q;
    ok_d         = 1'b0;
    fail_d       = 1'b0;
    overrun_d    = overrun_q | (any_edge & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (any_edge) begin
          state_d    = S_START;
          retry_d    = '0;
          byte_idx_d = '0;
          fields_d   = '0;
          if (lose_edge) begin
            fields_d.is_lose = LOSE_FLAG;
          end else begin
            fields_d.is_lose = ~LOSE_FLAG;
            fields_d.y       = ball_y_in;
            fields_d.vy      = ball_vy_in;
            fields_d.gravity = gravity_in;
            fields_d.fast    = fast_speed_in;
          end
        end
      end
      S_START: begin
        state_d    = S_SEND;
        byte_idx_d = '0;
      end
      S_SEND: begin
        if (i2c.i2c_nack || timed_out) begin
          attempt_fail = 1'b1;
        end else if (accepted) begin
          byte_idx_d = byte_idx_q + 3'd1;
          if (byte_idx_q == 3'(FRAME_LEN - 1)) state_d = S_WAIT_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // a done that coincides with a nack is a failed attempt
        if (i2c.i2c_nack || timed_out) begin
          attempt_fail = 1'b1;
        end else if (i2c.i2c_done) begin
          state_d = S_REPORT;
          ok_d    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_BACKOFF: begin
        if (bo_cnt_q >= BO_W'(BACKOFF_CYC - 1)) state_d = S_START;
        else                                     bo_cnt_d = bo_cnt_q + 1'b1;
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (attempt_fail) begin
      if (retry_q < RTY_W'(MAX_RETRY)) begin
        state_d = S_BACKOFF;
        retry_d = retry_q + 1'b1;
      end else begin
        state_d = S_REPORT;
        fail_d  = 1'b1;
      end
    end

    start_d = (state_d == S_START);
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      fields_q    <= '0;
      byte_idx_q  <= '0;
      tmo_cnt_q   <= '0;
      bo_cnt_q    <= '0;
      retry_q     <= '0;
      ball_prev_q <= 1'b0;
      lose_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fields_q    <= fields_d;
      byte_idx_q  <= byte_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bo_cnt_q    <= bo_cnt_d;
      retry_q     <= retry_d;
      ball_prev_q <= ball_prev_d;
      lose_prev_q <= lose_prev_d;
      armed_q     <= armed_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      overrun_q   <= overrun_d;
    end
  end

  assign i2c.i2c_start    = start_q;
  assign i2c.i2c_tx_valid = valid_q;
  assign i2c.i2c_tx_data  = valid_q ? packed_byte : 8'h00;
  assign busy             = busy_q;
  assign frame_ok         = ok_q;
  assign frame_fail       = fail_q;
  assign overrun          = overrun_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ball_handoff_sequencer.sv
// Directed bench for ball_handoff_sequencer: expected bytes are queued by the
// stimulus and popped by an independent monitor as the DUT transmits them.
module tb_ball_handoff_sequencer;
  import handoff_pkg::*;

  localparam int MAX_RETRY   = 3;
  localparam int TIMEOUT_CYC = 200;
  localparam int BACKOFF_CYC = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ball = 1'b0;
  logic       lose = 1'b0;
  logic [9:0] y = '0;
  logic [7:0] vy = '0;
  logic [1:0] g = '0;
  logic       fast = 1'b0;
  logic       busy, frame_ok, frame_fail, overrun;
  state_t     dbg_state;

  ball_handoff_sequencer_if bus();

  ball_handoff_sequencer #(
    .MAX_RETRY   (MAX_RETRY),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .BACKOFF_CYC (BACKOFF_CYC)
  ) dut (
    .clk_25MHZ             (clk),
    .reset_n               (reset_n),
    .ball_send_trigger     (ball),
    .send_lose_information (lose),
    .ball_y_in             (y),
    .ball_vy_in            (vy),
    .gravity_in            (g),
    .fast_speed_in         (fast),
    .i2c                   (bus),
    .busy                  (busy),
    .frame_ok              (frame_ok),
    .frame_fail            (frame_fail),
    .overrun               (overrun),
    .dbg_state             (dbg_state)
  );

  // clock / watchdog
  always #20 clk = ~clk;

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation still running after 20000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int n_start = 0, n_ok = 0, n_fail = 0, cyc = 0;
  int start_cyc[$];
  int nack_byte = 0, nack_budget = 0, dn_budget = 0;
  bit hold_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check(name, busy, 0);
  endtask

  task automatic check_gaps(input int base, input int count, input int gap, input string name);
    if (start_cyc.size() >= base + count + 1) begin
      for (int i = 0; i < count; i++)
        check(name, start_cyc[base+i+1] - start_cyc[base+i], gap);
    end else begin
      check({name, "_count"}, start_cyc.size() - base, count + 1);
    end
  endtask

  // I2C slave model: ready follows the bench, nack/done pulses on request
  initial begin
    int acc = 0;
    int done_cd = 0;
    forever begin
      @(negedge clk); #1;
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      if (!reset_n) begin
        acc = 0; done_cd = 0;
      end else begin
        if (bus.i2c_start) begin acc = 0; done_cd = 0; end
        if (done_cd > 0) begin
          done_cd--;
          if (done_cd == 0) begin
            bus.i2c_done = 1'b1;
            if (dn_budget > 0) begin bus.i2c_nack = 1'b1; dn_budget--; end
          end
        end
        if (bus.i2c_tx_valid && bus.i2c_tx_ready) begin
          if (nack_budget > 0 && acc == nack_byte) begin
            bus.i2c_nack = 1'b1; nack_budget--;
          end
          acc++;
          if (acc == 5 && !hold_done && !bus.i2c_nack) done_cd = 3;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (reset_n) begin
        if (bus.i2c_start) begin n_start++; start_cyc.push_back(cyc); end
        if (frame_ok)   n_ok++;
        if (frame_fail) n_fail++;
        if (bus.i2c_tx_valid) check("valid_only_in_send", dbg_state, S_SEND);
        if (bus.i2c_tx_valid && bus.i2c_tx_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_byte: got 0x%0h, expected no byte", bus.i2c_tx_data);
          end else begin
            exp_b = exp_q.pop_front();
            if (bus.i2c_tx_data !== exp_b) begin
              errors++;
              $display("FAIL tx_byte: got 0x%0h, expected 0x%0h", bus.i2c_tx_data, exp_b);
            end
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"},   bus.i2c_start, 0);
    check({tag, "_valid"},   bus.i2c_tx_valid, 0);
    check({tag, "_data"},    bus.i2c_tx_data, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_ok"},      frame_ok, 0);
    check({tag, "_fail"},    frame_fail, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_state"},   dbg_state, S_IDLE);
  endtask

  // directed stimulus
  initial begin
    int s0, o0, f0;
    int n;
    bus.i2c_tx_ready = 1'b1;
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // T1: ball frame, latency, field latching
    s0 = n_start; o0 = n_ok; f0 = n_fail;
    push5(8'h80, 8'hA5, 8'hFD, 8'h02, 8'h01);
    y = 10'h2A5; vy = 8'hFD; g = 2'd2; fast = 1'b1; ball = 1'b1;
    @(negedge clk);
    check("t1_start_n1", bus.i2c_start, 1);
    check("t1_busy_n1", busy, 1);
    check("t1_valid_n1", bus.i2c_tx_valid, 0);
    y = 10'h155; vy = 8'h11; g = 2'd1; fast = 1'b0;
    @(negedge clk);
    check("t1_valid_n2", bus.i2c_tx_valid, 1);
    check("t1_start_n2", bus.i2c_start, 0);
    wait_idle(200, "t1_idle");
    check("t1_starts", n_start - s0, 1);
    check("t1_ok", n_ok - o0, 1);
    check("t1_fail", n_fail - f0, 0);
    ball = 1'b0;
    repeat (2) @(negedge clk);

    // T2: ball and lose together, lose wins, no overrun
    s0 = n_start; o0 = n_ok;
    push5(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    y = 10'h3FF; vy = 8'h7E; g = 2'd3; fast = 1'b1;
    ball = 1'b1; lose = 1'b1;
    wait_idle(200, "t2_idle");
    check("t2_starts", n_start - s0, 1);
    check("t2_ok", n_ok - o0, 1);
    check("t2_overrun", overrun, 0);
    ball = 1'b0; lose = 1'b0;
    repeat (2) @(negedge clk);

    // T3: NACK on B2 twice, then clean
    s0 = n_start; o0 = n_ok;
    nack_byte = 2; nack_budget = 2;
    repeat (2) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'hF3); exp_q.push_back(8'h7F);
    end
    push5(8'h00, 8'hF3, 8'h7F, 8'h01, 8'h00);
    y = 10'h0F3; vy = 8'h7F; g = 2'd1; fast = 1'b0; ball = 1'b1;
    wait_idle(1000, "t3_idle");
    check("t3_starts", n_start - s0, 3);
    check("t3_ok", n_ok - o0, 1);
    check_gaps(s0, 2, BACKOFF_CYC + 4, "t3_start_gap");
    ball = 1'b0;
    repeat (2) @(negedge clk);

    // T4: done and nack in the same cycle counts as a failure
    s0 = n_start; o0 = n_ok; f0 = n_fail;
    dn_budget = 1;
    push5(8'h40, 8'h00, 8'h10, 8'h03, 8'h01);
    push5(8'h40, 8'h00, 8'h10, 8'h03, 8'h01);
    y = 10'h100; vy = 8'h10; g = 2'd3; fast = 1'b1; ball = 1'b1;
    wait_idle(1000, "t4_idle");
    check("t4_starts", n_start - s0, 2);
    check("t4_ok", n_ok - o0, 1);
    check("t4_fail", n_fail - f0, 0);
    check_gaps(s0, 1, BACKOFF_CYC + 9, "t4_start_gap");
    ball = 1'b0;
    repeat (2) @(negedge clk);

    // T5: ready held low -> timeouts, four attempts, frame_fail
    s0 = n_start; o0 = n_ok; f0 = n_fail;
    bus.i2c_tx_ready = 1'b0;
    lose = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_fail && n < 3000);
    check("t5_fail_seen", frame_fail, 1);
    check("t5_busy_in_report", busy, 1);
    @(negedge clk);
    check("t5_busy_after", busy, 0);
    check("t5_starts", n_start - s0, MAX_RETRY + 1);
    check("t5_ok", n_ok - o0, 0);
    check("t5_fail", n_fail - f0, 1);
    check_gaps(s0, 3, TIMEOUT_CYC + BACKOFF_CYC + 2, "t5_start_gap");
    bus.i2c_tx_ready = 1'b1;
    lose = 1'b0;
    repeat (2) @(negedge clk);

    // T6: ball held 1000 cycles, lose edge during SEND
    s0 = n_start; o0 = n_ok;
    check("t6_overrun_before", overrun, 0);
    push5(8'hC0, 8'hFF, 8'h80, 8'h00, 8'h00);
    y = 10'h3FF; vy = 8'h80; g = 2'd0; fast = 1'b0; ball = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_in_send", dbg_state, S_SEND);
    lose = 1'b1;
    repeat (997) @(negedge clk);
    check("t6_starts", n_start - s0, 1);
    check("t6_ok", n_ok - o0, 1);
    check("t6_overrun", overrun, 1);
    check("t6_busy", busy, 0);
    ball = 1'b0; lose = 1'b0;
    repeat (2) @(negedge clk);

    // T7: reset during WAIT_DONE, then a level held through reset release
    s0 = n_start; o0 = n_ok; f0 = n_fail;
    hold_done = 1'b1;
    push5(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    lose = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != S_WAIT_DONE && n < 50);
    check("t7_reach_wait_done", dbg_state, S_WAIT_DONE);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t7_async");
    @(negedge clk);
    lose = 1'b0; ball = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t7_no_start_after_release", n_start - s0, 1);
    check("t7_busy", busy, 0);
    check("t7_no_ok", n_ok - o0, 0);
    check("t7_no_fail", n_fail - f0, 0);
    hold_done = 1'b0;
    ball = 1'b0;
    repeat (2) @(negedge clk);

    // T8: a fresh edge after reset still starts a frame
    o0 = n_ok;
    push5(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    lose = 1'b1;
    wait_idle(200, "t8_idle");
    check("t8_ok", n_ok - o0, 1);
    lose = 1'b0;
    repeat (2) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
